// File: rtl/nn_pkg.sv
// Shared definitions for the network datapath: layer sequencer state
// encoding and the default layer dimensions used by the network top.
package nn_pkg;

  localparam int unsigned NN_WIDTH_OUT  = 32;
  localparam int unsigned NN_L1_INPUTS  = 784;
  localparam int unsigned NN_L1_NEURONS = 10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN1,
    ST_DRAIN2,
    ST_WRITE,
    ST_DONE
  } seq_state_t;

endpackage

// File: rtl/layer_mac_sequencer_mac_align_pipe.sv
// mac_align_pipe: delays the fetch-issue strobes so MAC clken/sload line up
// with data returned by registered (1-cycle latency) memories.
//   clk, aclr_n  : clock, synchronous active-low reset
//   issue        : a read address is being issued this cycle
//   issue_first  : the issued read is the first of a neuron
//   clken, sload : MAC controls, aligned with the read data
module mac_align_pipe (
  input  logic clk,
  input  logic aclr_n,
  input  logic issue,
  input  logic issue_first,
  output logic clken,
  output logic sload
);

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      clken <= 1'b0;
      sload <= 1'b0;
    end else begin
      clken <= issue;
      sload <= issue_first;
    end
  end

endmodule

// File: rtl/layer_mac_sequencer.sv
// layer_mac_sequencer: runs one fully connected layer on a shared signed MAC.
// Per neuron: N_INPUTS activation/weight reads, two drain cycles, bias add,
// optional ReLU, one-cycle result strobe.
//   clk, aclr_n          : clock, synchronous active-low reset
//   start, busy, done    : layer handshake with the network FSM
//   in_addr, w_addr      : activation / weight read addresses (registered reads)
//   b_addr, bias_data    : bias ROM address (= neuron) and its registered data
//   mac_clken/sload/aclr : MAC controls
//   mac_result           : MAC accumulator output
//   out_valid/index/data : per-neuron result strobe
module layer_mac_sequencer
  import nn_pkg::*;
#(
  parameter int unsigned N_INPUTS  = NN_L1_INPUTS,
  parameter int unsigned N_NEURONS = NN_L1_NEURONS,
  parameter int unsigned WIDTH_OUT = NN_WIDTH_OUT,
  parameter int unsigned RELU      = 1,
  parameter int unsigned IN_AW     = $clog2(N_INPUTS),
  parameter int unsigned W_AW      = $clog2(N_INPUTS * N_NEURONS),
  parameter int unsigned N_AW      = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
  input  logic                 clk,
  input  logic                 aclr_n,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  output logic [IN_AW-1:0]     in_addr,
  output logic [W_AW-1:0]      w_addr,
  output logic [N_AW-1:0]      b_addr,
  input  logic [WIDTH_OUT-1:0] bias_data,
  output logic                 mac_clken,
  output logic                 mac_sload,
  output logic                 mac_aclr,
  input  logic [WIDTH_OUT-1:0] mac_result,
  output logic                 out_valid,
  output logic [N_AW-1:0]      out_index,
  output logic [WIDTH_OUT-1:0] out_data
);

  seq_state_t state, state_nxt;

  logic [N_AW-1:0]      neuron;
  logic                 last_in;
  logic                 last_neuron;
  logic                 start_acc;
  logic                 issue;
  logic                 issue_first;
  logic [WIDTH_OUT-1:0] sum;

  assign b_addr = neuron;

  always_ff @(posedge clk) begin
    if (!aclr_n) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    last_in     = (in_addr == IN_AW'(N_INPUTS - 1));
    last_neuron = (neuron == N_AW'(N_NEURONS - 1));
    start_acc   = (state == ST_IDLE) && start;
    issue       = (state == ST_FETCH);
    issue_first = issue && (in_addr == '0);
    // wrap-around add; the MAC already holds the complete dot product here
    sum         = mac_result + bias_data;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  if (last_in) state_nxt = ST_DRAIN1;
      ST_DRAIN1: state_nxt = ST_DRAIN2;
      ST_DRAIN2: state_nxt = ST_WRITE;
      ST_WRITE:  state_nxt = last_neuron ? ST_DONE : ST_FETCH;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!aclr_n) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      mac_aclr  <= 1'b1;
      in_addr   <= '0;
      w_addr    <= '0;
      neuron    <= '0;
      out_valid <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
    end else begin
      mac_aclr  <= start_acc;
      done      <= 1'b0;
      out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          in_addr <= '0;
          w_addr  <= '0;
          neuron  <= '0;
          if (start) busy <= 1'b1;
        end
        ST_FETCH: begin
          // weight address is a flat running counter across neurons
          w_addr  <= w_addr + W_AW'(1);
          in_addr <= last_in ? '0 : in_addr + IN_AW'(1);
        end
        ST_DRAIN2: begin
          // result registered here so it is presented during WRITE
          out_valid <= 1'b1;
          out_index <= neuron;
          out_data  <= ((RELU != 0) && sum[WIDTH_OUT-1]) ? '0 : sum;
        end
        ST_WRITE: begin
          if (last_neuron) done <= 1'b1;
          else             neuron <= neuron + N_AW'(1);
        end
        ST_DONE: busy <= 1'b0;
        default: ;
      endcase
    end
  end

  mac_align_pipe u_align (
    .clk         (clk),
    .aclr_n      (aclr_n),
    .issue       (issue),
    .issue_first (issue_first),
    .clken       (mac_clken),
    .sload       (mac_sload)
  );

endmodule

// File: tb/tb_layer_mac_sequencer.sv
module tb_layer_mac_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic aclr_n = 1'b0;
  logic start_a = 1'b0, start_b = 1'b0;

  // shared memory contents (both instances: N_INPUTS=4, N_NEURONS=2)
  logic signed [15:0] act_mem [4];
  logic signed [15:0] w_mem   [8];
  logic        [31:0] bias_mem[2];

  // instance A: RELU=1
  logic        busy_a, done_a, clken_a, sload_a, aclr_a, ov_a;
  logic [1:0]  in_addr_a;
  logic [2:0]  w_addr_a;
  logic        b_addr_a, oi_a;
  logic [31:0] bias_a, res_a, od_a;
  logic signed [15:0] aq_a, wq_a;

  // instance B: RELU=0
  logic        busy_b, done_b, clken_b, sload_b, aclr_b, ov_b;
  logic [1:0]  in_addr_b;
  logic [2:0]  w_addr_b;
  logic        b_addr_b, oi_b;
  logic [31:0] bias_b, res_b, od_b;
  logic signed [15:0] aq_b, wq_b;

  layer_mac_sequencer #(.N_INPUTS(4), .N_NEURONS(2), .WIDTH_OUT(32), .RELU(1)) dut_a (
    .clk(clk), .aclr_n(aclr_n), .start(start_a), .busy(busy_a), .done(done_a),
    .in_addr(in_addr_a), .w_addr(w_addr_a), .b_addr(b_addr_a), .bias_data(bias_a),
    .mac_clken(clken_a), .mac_sload(sload_a), .mac_aclr(aclr_a), .mac_result(res_a),
    .out_valid(ov_a), .out_index(oi_a), .out_data(od_a));

  layer_mac_sequencer #(.N_INPUTS(4), .N_NEURONS(2), .WIDTH_OUT(32), .RELU(0)) dut_b (
    .clk(clk), .aclr_n(aclr_n), .start(start_b), .busy(busy_b), .done(done_b),
    .in_addr(in_addr_b), .w_addr(w_addr_b), .b_addr(b_addr_b), .bias_data(bias_b),
    .mac_clken(clken_b), .mac_sload(sload_b), .mac_aclr(aclr_b), .mac_result(res_b),
    .out_valid(ov_b), .out_index(oi_b), .out_data(od_b));

  // registered memories and MAC models
  always @(posedge clk) begin
    aq_a   <= act_mem[in_addr_a];
    wq_a   <= w_mem[w_addr_a];
    bias_a <= bias_mem[b_addr_a];
    aq_b   <= act_mem[in_addr_b];
    wq_b   <= w_mem[w_addr_b];
    bias_b <= bias_mem[b_addr_b];
  end

  logic signed [31:0] prod_a, prod_b;
  assign prod_a = aq_a * wq_a;
  assign prod_b = aq_b * wq_b;

  always @(posedge clk) begin
    if (aclr_a)       res_a <= '0;
    else if (clken_a) res_a <= sload_a ? prod_a : res_a + prod_a;
    if (aclr_b)       res_b <= '0;
    else if (clken_b) res_b <= sload_b ? prod_b : res_b + prod_b;
  end

  int pcyc = 0;
  always @(posedge clk) pcyc <= pcyc + 1;

  // event monitors
  int a_str = 0, a_done = 0, a_done_at = 0, a_busy_done = 0;
  int b_str = 0, b_done = 0, b_sl = 0, b_sl_bad = 0;
  logic [31:0] a_res [2];
  logic [31:0] b_res [2];
  logic b_prev_clken = 1'b0;

  always @(negedge clk) begin
    if (ov_a) begin a_str++; a_res[oi_a] = od_a; end
    if (done_a) begin a_done++; a_done_at = pcyc; a_busy_done = int'(busy_a); end
    if (ov_b) begin b_str++; b_res[oi_b] = od_b; end
    if (done_b) b_done++;
    if (sload_b) begin
      b_sl++;
      if (!clken_b || b_prev_clken) b_sl_bad++;
    end
    if (clken_b && !b_prev_clken && !sload_b) b_sl_bad++;
    b_prev_clken = clken_b;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_dones(input int ea, input int eb);
    int n = 0;
    while ((a_done < ea || b_done < eb) && n < 80) begin
      tick();
      n++;
    end
    chk("done_timeout", 32'((a_done >= ea) && (b_done >= eb)), 32'd1);
    tick();
    tick();
  endtask

  task automatic load_base();
    act_mem = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};
    w_mem   = '{16'sd1, 16'sd1, 16'sd1, 16'sd1, -16'sd1, -16'sd2, -16'sd3, -16'sd4};
    bias_mem = '{32'd5, 32'd0};
  endtask

  int t0, sa, da, sb, db, d1;

  initial begin
    load_base();
    a_res = '{32'hDEAD, 32'hDEAD};
    b_res = '{32'hDEAD, 32'hDEAD};

    // reset state
    tick(); tick();
    chk("rst_busy",    32'(busy_a), 32'd0);
    chk("rst_done",    32'(done_a), 32'd0);
    chk("rst_valid",   32'(ov_a), 32'd0);
    chk("rst_clken",   32'(clken_a), 32'd0);
    chk("rst_sload",   32'(sload_a), 32'd0);
    chk("rst_macaclr", 32'(aclr_a), 32'd1);
    chk("rst_addrs",   32'({in_addr_a, w_addr_a, b_addr_a, oi_a}), 32'd0);
    chk("rst_data",    od_a, 32'd0);
    aclr_n = 1'b1;
    tick(); tick();

    // basic layer on both instances, stray start pulse into A during FETCH
    sa = a_str; da = a_done; sb = b_str; db = b_done;
    t0 = pcyc;
    start_a = 1'b1; start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    chk("fetch_busy", 32'(busy_a), 32'd1);
    chk("fetch_waddr0", 32'(w_addr_a), 32'd0);
    chk("start_macaclr", 32'(aclr_a), 32'd1);
    tick(); tick();
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_dones(da + 1, db + 1);
    chk("relu_n0", a_res[0], 32'd15);
    chk("relu_n1", a_res[1], 32'd0);
    chk("lin_n0",  b_res[0], 32'd15);
    chk("lin_n1",  b_res[1], 32'(-30));
    chk("done_latency", 32'(a_done_at - t0), 32'd15);
    chk("busy_in_done", 32'(a_busy_done), 32'd1);
    chk("a_strobes", 32'(a_str - sa), 32'd2);
    chk("a_dones",   32'(a_done - da), 32'd1);
    chk("b_strobes", 32'(b_str - sb), 32'd2);
    chk("sload_count", 32'(b_sl), 32'd2);
    chk("sload_align", 32'(b_sl_bad), 32'd0);
    chk("held_data", od_b, 32'(-30));
    chk("held_index", 32'(oi_b), 32'd1);
    chk("idle_busy", 32'(busy_a), 32'd0);

    // reset in the middle of neuron 1's FETCH
    sa = a_str; da = a_done;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    repeat (8) tick();
    aclr_n = 1'b0;
    tick();
    aclr_n = 1'b1;
    chk("midrst_busy",  32'(busy_a), 32'd0);
    chk("midrst_valid", 32'(ov_a), 32'd0);
    chk("midrst_clken", 32'(clken_a), 32'd0);
    repeat (20) tick();
    chk("midrst_strobes", 32'(a_str - sa), 32'd1);
    chk("midrst_dones",   32'(a_done - da), 32'd0);
    sa = a_str; da = a_done;
    a_res = '{32'hDEAD, 32'hDEAD};
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    wait_dones(da + 1, 0);
    chk("restart_n0", a_res[0], 32'd15);
    chk("restart_n1", a_res[1], 32'd0);
    chk("restart_strobes", 32'(a_str - sa), 32'd2);

    // start held high: back-to-back layers
    sa = a_str; da = a_done;
    start_a = 1'b1;
    for (int n = 0; n < 40 && a_done == da; n++) tick();
    chk("b2b_first_done", 32'(a_done - da), 32'd1);
    d1 = a_done_at;
    chk("b2b_idle_busy", 32'(busy_a), 32'd0);
    tick();
    chk("b2b_fetch_busy", 32'(busy_a), 32'd1);
    chk("b2b_waddr", 32'(w_addr_a), 32'd0);
    chk("b2b_inaddr", 32'(in_addr_a), 32'd0);
    start_a = 1'b0;
    wait_dones(da + 2, 0);
    chk("b2b_period", 32'(a_done_at - d1), 32'd16);
    chk("b2b_strobes", 32'(a_str - sa), 32'd4);
    chk("b2b_n0", a_res[0], 32'd15);

    // overflow wrap
    for (int i = 0; i < 4; i++) begin
      act_mem[i] = 16'sh7FFF;
      w_mem[i]   = 16'sh7FFF;
    end
    bias_mem[0] = 32'h7FFF_FFFF;
    da = a_done; db = b_done;
    start_a = 1'b1; start_b = 1'b1;
    tick();
    start_a = 1'b0; start_b = 1'b0;
    wait_dones(da + 1, db + 1);
    chk("ovf_relu_n0", a_res[0], 32'h7FFC_0003);
    chk("ovf_relu_n1", a_res[1], 32'd0);
    chk("ovf_lin_n0",  b_res[0], 32'h7FFC_0003);
    chk("ovf_lin_n1",  b_res[1], 32'hFFFB_000A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
